// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

   localparam int LINE_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2
   } icache_state_t;

   typedef struct packed {
      logic              valid;
      logic [LINE_W-1:0] tag;
      logic [LINE_W-1:0] data;
   } icache_line_t;

   function automatic int idx_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_w(input int word_w, input int num_sets);
      return word_w - $clog2(num_sets) - 2;
   endfunction

endpackage

// File: rtl/icache_array.sv
// Line storage: combinational read, single write port, per-index valid clear.
module icache_array
   import icache_pkg::*;
#(
   parameter  int NUM_SETS = 16,
   parameter  int WORD_W   = 32,
   localparam int IDX_W    = idx_w(NUM_SETS),
   localparam int TAG_W    = tag_w(WORD_W, NUM_SETS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   output icache_line_t      rd_line,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              clr_en,
   input  logic [IDX_W-1:0]  clr_idx
);

   logic [NUM_SETS-1:0] valid_r;
   logic [TAG_W-1:0]    tag_r  [NUM_SETS];
   logic [WORD_W-1:0]   data_r [NUM_SETS];

   // Valid bits are the only reset state; tag/data are qualified by them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= {NUM_SETS{1'b0}};
      end else if (clr_en) begin
         valid_r[clr_idx] <= 1'b0;
      end else if (wr_en) begin
         valid_r[wr_idx] <= 1'b1;
      end
   end

   // Tag and data write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_r[wr_idx]  <= wr_tag;
         data_r[wr_idx] <= wr_data;
      end
   end

   // Combinational read port
   always_comb begin
      rd_line.valid = valid_r[rd_idx];
      rd_line.tag   = LINE_W'(tag_r[rd_idx]);
      rd_line.data  = LINE_W'(data_r[rd_idx]);
   end

endmodule

// File: rtl/icache_responder.sv
// Fetch-side responder of a direct-mapped, one-word-per-line read-only
// instruction cache with RAM refill and whole-cache flush.
module icache_responder
   import icache_pkg::*;
#(
   parameter int NUM_SETS = 16,
   parameter int WORD_W   = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic [WORD_W-1:0] imemload,
   output logic              ihit,
   input  logic              flush,
   output logic              ramREN,
   output logic [WORD_W-1:0] ramaddr,
   input  logic [WORD_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              busy
);

   localparam int IDX_W = idx_w(NUM_SETS);
   localparam int TAG_W = tag_w(WORD_W, NUM_SETS);

   icache_state_t       state_r, next_state_s;
   logic [WORD_W-3:0]   fill_addr_r;
   logic                flush_pend_r;
   logic [IDX_W-1:0]    flush_cnt_r;

   logic [IDX_W-1:0]    req_idx_s, fill_idx_s;
   logic [TAG_W-1:0]    req_tag_s, fill_tag_s;
   icache_line_t        line_s;
   logic                hit_s, miss_s, wr_en_s, clr_en_s, set_pend_s, flush_last_s;
   logic                unused_byte_sel_s;

   assign req_idx_s         = imemaddr[IDX_W+1:2];
   assign req_tag_s         = imemaddr[WORD_W-1:IDX_W+2];
   assign fill_idx_s        = fill_addr_r[IDX_W-1:0];
   assign fill_tag_s        = fill_addr_r[WORD_W-3:IDX_W];
   assign flush_last_s      = (flush_cnt_r == IDX_W'(NUM_SETS - 1));
   assign unused_byte_sel_s = ^imemaddr[1:0];

   icache_array #(
      .NUM_SETS (NUM_SETS),
      .WORD_W   (WORD_W)
   ) u_array (
      .clk     (CLK),
      .rst     (RST),
      .rd_idx  (req_idx_s),
      .rd_line (line_s),
      .wr_en   (wr_en_s),
      .wr_idx  (fill_idx_s),
      .wr_tag  (fill_tag_s),
      .wr_data (ramload),
      .clr_en  (clr_en_s),
      .clr_idx (flush_cnt_r)
   );

   // Next-state and handshake decode; flush in IDLE wins over a miss but not over a hit
   always_comb begin
      next_state_s = state_r;
      hit_s        = 1'b0;
      miss_s       = 1'b0;
      wr_en_s      = 1'b0;
      clr_en_s     = 1'b0;
      set_pend_s   = 1'b0;
      case (state_r)
         IDLE: begin
            hit_s = imemREN & line_s.valid & (line_s.tag == LINE_W'(req_tag_s));
            if (flush) begin
               next_state_s = FLUSH;
            end else if (imemREN && !hit_s) begin
               next_state_s = FILL;
               miss_s       = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         FILL: begin
            set_pend_s = flush;
            if (ram_ready) begin
               wr_en_s      = 1'b1;
               next_state_s = (flush_pend_r || flush) ? FLUSH : IDLE;
            end else begin
               next_state_s = FILL;
            end
         end
         FLUSH: begin
            clr_en_s = 1'b1;
            if (flush_last_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = FLUSH;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, fill address, pending flush and flush sweep counter
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r      <= IDLE;
         fill_addr_r  <= {(WORD_W-2){1'b0}};
         flush_pend_r <= 1'b0;
         flush_cnt_r  <= {IDX_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (miss_s) begin
            fill_addr_r <= imemaddr[WORD_W-1:2];
         end
         if (state_r == FLUSH && flush_last_s) begin
            flush_pend_r <= 1'b0;
         end else if (set_pend_s) begin
            flush_pend_r <= 1'b1;
         end
         if (clr_en_s) begin
            flush_cnt_r <= flush_last_s ? {IDX_W{1'b0}} : flush_cnt_r + IDX_W'(1);
         end
      end
   end

   assign ihit     = hit_s;
   assign imemload = hit_s ? WORD_W'(line_s.data) : {WORD_W{1'b0}};
   assign ramREN   = (state_r == FILL);
   assign ramaddr  = (state_r == FILL) ? {fill_addr_r, 2'b00} : {WORD_W{1'b0}};
   assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench: a simple cache model predicts hit/miss latency and data,
// a RAM model answers fills, and a monitor checks every ihit against the queue.
module tb_icache_responder;

   localparam int NS = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        imemREN = 1'b0;
   logic [31:0] imemaddr = 32'h0;
   logic        flush = 1'b0;
   logic [31:0] ramload = 32'h0;
   logic        ram_ready = 1'b0;
   logic [31:0] imemload, ramaddr;
   logic        ihit, ramREN, busy;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ram_lat = 3;
   int          ram_wait = 0;
   int          busy_run = 0;
   int          last_busy_run = 0;
   exp_t        sb_q[$];
   logic [31:0] fill_q[$];
   logic [31:0] fill_hold = 32'h0;
   bit          m_valid[NS];
   logic [31:0] m_tag[NS];

   icache_responder #(.NUM_SETS(NS), .WORD_W(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .imemREN   (imemREN),
      .imemaddr  (imemaddr),
      .imemload  (imemload),
      .ihit      (ihit),
      .flush     (flush),
      .ramREN    (ramREN),
      .ramaddr   (ramaddr),
      .ramload   (ramload),
      .ram_ready (ram_ready),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   initial forever begin
      @(posedge CLK);
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      logic [31:0] w;
      w = addr & ~32'h3;
      if (w == 32'h40) return 32'hDEADBEEF;
      return (w * 32'h9E3779B1) ^ 32'hA5A55A5A;
   endfunction

   // Reference cache: line index is word number modulo NS, tag is the rest.
   function automatic bit model_hit(input logic [31:0] addr);
      int idx;
      idx = int'((addr / 4) % NS);
      return m_valid[idx] && (m_tag[idx] == addr / (4 * NS));
   endfunction

   function automatic void model_install(input logic [31:0] addr);
      int idx;
      idx = int'((addr / 4) % NS);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr / (4 * NS);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
   endfunction

   // Monitor: invariants every cycle, scoreboard pop on each ihit, busy run length.
   initial forever begin
      exp_t e;
      @(negedge CLK);
      if (!RST) begin
         check("invariants", {29'd0, ihit & ramREN, ihit & busy, !ihit && (imemload != 32'h0)}, 32'h0);
         if (busy) begin
            busy_run++;
         end else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
         end
         if (ihit) begin
            if (sb_q.size() == 0) begin
               check("ihit_without_request", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               check("imemload", imemload, e.data);
               check("ihit_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   // Backing RAM: answers after ram_lat FILL cycles, checks address and its stability.
   initial forever begin
      @(negedge CLK);
      if (ramREN) begin
         ram_wait++;
         if (ram_wait == 1) begin
            if (fill_q.size() == 0) begin
               check("fill_without_miss", 32'(fill_q.size()), 32'd1);
            end else begin
               fill_hold = fill_q.pop_front();
               check("ramaddr", ramaddr, fill_hold);
            end
         end else begin
            check("ramaddr_stable", ramaddr, fill_hold);
         end
         if (ram_wait >= ram_lat) begin
            ram_ready = 1'b1;
            ramload   = mem_word(ramaddr);
         end else begin
            ram_ready = 1'b0;
            ramload   = $urandom;
         end
      end else begin
         ram_wait  = 0;
         ram_ready = 1'($urandom_range(0, 1));
         ramload   = $urandom;
      end
   end

   task automatic wait_ihit();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (ihit) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("ihit_timeout", 32'(ihit), 32'd1);
         sb_q.delete();
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_flush_done(input int exp_run);
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!busy) break;
      end
      @(posedge CLK);
      #1;
      check("busy_cycles", 32'(last_busy_run), 32'(exp_run));
      model_clear();
   endtask

   // One fetch held until ihit; with_flush is only used on a predicted hit.
   task automatic fetch(input logic [31:0] addr, input bit with_flush);
      exp_t e;
      bit   hit;
      hit      = model_hit(addr);
      imemREN  = 1'b1;
      imemaddr = addr;
      flush    = with_flush;
      e.data   = mem_word(addr);
      e.cyc    = cyc + (hit ? 0 : ram_lat + 1);
      sb_q.push_back(e);
      if (!hit) begin
         fill_q.push_back(addr & ~32'h3);
         model_install(addr);
      end
      wait_ihit();
      imemREN = 1'b0;
      flush   = 1'b0;
      if (with_flush) wait_flush_done(NS);
   endtask

   task automatic solo_flush();
      flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      repeat (4) begin @(posedge CLK); #1; end
      flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      wait_flush_done(NS);
   endtask

   initial begin
      exp_t        e;
      int          c0;
      logic [31:0] addr;
      int          r;

      model_clear();
      repeat (3) @(posedge CLK);
      #1;
      check("rst_ihit", 32'(ihit), 32'h0);
      check("rst_imemload", imemload, 32'h0);
      check("rst_ramREN", 32'(ramREN), 32'h0);
      check("rst_ramaddr", ramaddr, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      RST = 1'b0;
      @(posedge CLK); #1;

      ram_lat = 3;
      fetch(32'h40, 1'b0);
      fetch(32'h40, 1'b0);
      fetch(32'h43, 1'b0);
      fetch(32'h80, 1'b0);
      fetch(32'h40, 1'b0);
      fetch(32'h40, 1'b1);

      // Redirect while a fill of 0x100 is outstanding
      imemREN  = 1'b1;
      imemaddr = 32'h100;
      fill_q.push_back(32'h100);
      model_install(32'h100);
      c0 = cyc;
      @(posedge CLK); #1;
      imemaddr = 32'h204;
      e.data   = mem_word(32'h204);
      e.cyc    = c0 + ram_lat + 1 + (model_hit(32'h204) ? 0 : ram_lat + 1);
      if (!model_hit(32'h204)) begin
         fill_q.push_back(32'h204);
         model_install(32'h204);
      end
      sb_q.push_back(e);
      wait_ihit();
      imemREN = 1'b0;
      fetch(32'h100, 1'b0);

      // Flush one cycle into a fill
      imemREN  = 1'b1;
      imemaddr = 32'h300;
      fill_q.push_back(32'h300);
      @(posedge CLK); #1;
      flush   = 1'b1;
      imemREN = 1'b0;
      @(posedge CLK); #1;
      flush = 1'b0;
      wait_flush_done(ram_lat + NS);
      fetch(32'h100, 1'b0);
      fetch(32'h300, 1'b0);

      solo_flush();

      // Reset in the middle of a fill
      imemREN  = 1'b1;
      imemaddr = 32'h500;
      fill_q.push_back(32'h500);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      #1;
      check("rst_fill_ramREN", 32'(ramREN), 32'h0);
      check("rst_fill_busy", 32'(busy), 32'h0);
      check("rst_fill_ihit", 32'(ihit), 32'h0);
      imemREN = 1'b0;
      model_clear();
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      fetch(32'h500, 1'b0);

      for (int i = 0; i < 80; i++) begin
         r       = int'($urandom_range(0, 9));
         ram_lat = int'($urandom_range(1, 4));
         addr    = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         if (r == 0) begin
            solo_flush();
         end else if (r == 1 && model_hit(addr)) begin
            fetch(addr, 1'b1);
         end else begin
            fetch(addr, 1'b0);
         end
      end

      repeat (2) @(posedge CLK);
      check("sb_drained", 32'(sb_q.size()), 32'h0);
      check("fills_drained", 32'(fill_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
